// File: rtl/fifo_ctrl.sv
// fifo_ctrl: 32-entry FIFO controller driving a single-port memory.
// Define FIFO_CTRL_ERR_EN to build the sticky overflow/underflow flags.
module fifo_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    output logic              push_ack,
    input  logic              pop,
    output logic              pop_ack,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic {
        PRIO_PUSH = 1'b0,
        PRIO_POP  = 1'b1
    } prio_e;

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    prio_e             prio_q, prio_d;
    logic              dout_valid_q, dout_valid_d;
    logic              push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Arbitrate the single memory port; acks are held low during reset.
    always_comb begin
        push_ack = 1'b0;
        pop_ack  = 1'b0;
        prio_d   = prio_q;
        if (reset_n && !clear) begin
            if (push_ok && pop_ok) begin
                if (prio_q == PRIO_PUSH) begin
                    pop_ack = 1'b1;
                    prio_d  = PRIO_POP;
                end else begin
                    push_ack = 1'b1;
                    prio_d   = PRIO_PUSH;
                end
            end else begin
                push_ack = push_ok;
                pop_ack  = pop_ok;
            end
        end
        if (clear) begin
            prio_d = PRIO_PUSH;
        end
    end

    assign mem_cen    = push_ack | pop_ack;
    assign mem_wen    = push_ack;
    assign mem_addr   = push_ack ? wr_ptr_q : rd_ptr_q;
    assign mem_din    = din;
    assign dout       = mem_dout;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;

    // Pointer, occupancy and read-strobe next state.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_valid_d = pop_ack;
        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            dout_valid_d = 1'b0;
        end else begin
            if (push_ack) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
            if (pop_ack) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
        end
    end

    // Core state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prio_q       <= PRIO_PUSH;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            prio_q       <= prio_d;
            dout_valid_q <= dout_valid_d;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; a request losing arbitration is not an error.
    always_comb begin
        overflow_d  = overflow_q | (push & full);
        underflow_d = underflow_q | (pop & empty);
        if (clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed and random checks of fifo_ctrl
// against a queue-based reference and a memory model.
module tb_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        push;
    logic [31:0] din;
    logic        push_ack;
    logic        pop;
    logic        pop_ack;
    logic [31:0] dout;
    logic        dout_valid;
    logic        full;
    logic        empty;
    logic [5:0]  count;
    logic        overflow;
    logic        underflow;
    logic        mem_cen;
    logic        mem_wen;
    logic [4:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    always #5 clk = ~clk;

    fifo_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .push       (push),
        .din        (din),
        .push_ack   (push_ack),
        .pop        (pop),
        .pop_ack    (pop_ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .mem_cen    (mem_cen),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    logic [31:0] mem [32];
    logic [31:0] mem_rd;

    always @(posedge clk) begin
        if (mem_cen) begin
            if (mem_wen) mem[mem_addr] <= mem_din;
            else         mem_rd <= mem[mem_addr];
        end
    end
    assign mem_dout = mem_rd;

    logic [31:0] q [$];
    int          wr_n;
    int          rd_n;
    bit          pop_turn;
    bit          m_ovf;
    bit          m_unf;
    bit          m_valid;
    logic [31:0] m_data;
    int          nerr = 0;
    int          nchk = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        wr_n     = 0;
        rd_n     = 0;
        pop_turn = 1'b1;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_valid  = 1'b0;
    endtask

    task automatic chk_state();
        bit eo;
        bit eu;
`ifdef FIFO_CTRL_ERR_EN
        eo = m_ovf;
        eu = m_unf;
`else
        eo = 1'b0;
        eu = 1'b0;
`endif
        chk("count", count, q.size());
        chk("full", full, q.size() == 32);
        chk("empty", empty, q.size() == 0);
        chk("dout_valid", dout_valid, m_valid);
        if (m_valid) chk("dout", dout, m_data);
        chk("overflow", overflow, eo);
        chk("underflow", underflow, eu);
    endtask

    task automatic chk_reset();
        chk("rst_push_ack", push_ack, 0);
        chk("rst_pop_ack", pop_ack, 0);
        chk("rst_mem_cen", mem_cen, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
    endtask

    // One clock cycle: drive, check grant, advance model, check state.
    task automatic cyc(input bit p, input bit o, input logic [31:0] d,
                       input bit c, output bit ga, output bit ra);
        bit pl;
        bit ol;
        push  = p;
        pop   = o;
        din   = d;
        clear = c;
        #1;
        pl = p && (q.size() < 32);
        ol = o && (q.size() > 0);
        ga = 1'b0;
        ra = 1'b0;
        if (!c) begin
            if (pl && ol) begin
                if (pop_turn) ra = 1'b1;
                else          ga = 1'b1;
            end else begin
                ga = pl;
                ra = ol;
            end
        end
        chk("push_ack", push_ack, ga);
        chk("pop_ack", pop_ack, ra);
        chk("mem_cen", mem_cen, ga | ra);
        chk("mem_wen", mem_wen, ga);
        if (ga) chk("wr_addr", mem_addr, wr_n % 32);
        if (ra) chk("rd_addr", mem_addr, rd_n % 32);
        if (ga) chk("mem_din", mem_din, d);
        @(posedge clk);
        if (c) begin
            m_reset();
        end else begin
            if (p && q.size() == 32) m_ovf = 1'b1;
            if (o && q.size() == 0)  m_unf = 1'b1;
            if (pl && ol) pop_turn = !pop_turn;
            if (ra) begin
                m_data = q.pop_front();
                rd_n++;
            end
            if (ga) begin
                q.push_back(d);
                wr_n++;
            end
            m_valid = ra;
        end
        #1;
        chk_state();
    endtask

    initial begin
        bit          ga;
        bit          ra;
        bit          pp;
        bit          po;
        bit          c;
        logic [31:0] pd;

        reset_n = 1'b0;
        push    = 1'b1;
        pop     = 1'b1;
        clear   = 1'b0;
        din     = 32'h55;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        push = 1'b0;
        pop  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) cyc(1, 0, 32'(i + 1), 0, ga, ra);
        chk("fill_full", full, 1);
        chk("fill_count", count, 32);

        repeat (2) cyc(1, 0, 32'h99, 0, ga, ra);
        cyc(0, 0, 0, 0, ga, ra);

        for (int i = 0; i < 32; i++) cyc(0, 1, 0, 0, ga, ra);
        cyc(0, 0, 0, 0, ga, ra);
        cyc(0, 1, 0, 0, ga, ra);
        cyc(0, 0, 0, 0, ga, ra);

        for (int i = 0; i < 5; i++) cyc(1, 0, 32'(32'h40 + i), 0, ga, ra);
        pd = 32'h50;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, pd, 0, ga, ra);
            if (ga) pd = pd + 1;
        end
        chk("cont_count", count, 5);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, ga, ra);

        cyc(0, 0, 0, 1, ga, ra);
        for (int i = 0; i < 20; i++) cyc(1, 0, 32'(32'h100 + i), 0, ga, ra);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, ga, ra);
        for (int i = 0; i < 20; i++) cyc(1, 0, 32'(32'h200 + i), 0, ga, ra);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, ga, ra);
        cyc(0, 0, 0, 0, ga, ra);

        for (int i = 0; i < 10; i++) cyc(1, 0, 32'(32'h300 + i), 0, ga, ra);
        cyc(0, 1, 0, 0, ga, ra);
        cyc(1, 1, 32'h3ff, 1, ga, ra);
        cyc(1, 0, 32'h400, 0, ga, ra);
        cyc(0, 1, 0, 0, ga, ra);

        pp = 1'b0;
        po = 1'b0;
        pd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pp && (i < 300 ? $urandom_range(3) != 0
                                : $urandom_range(3) == 0)) begin
                pp = 1'b1;
                pd = $urandom;
            end
            if (!po && (i < 300 ? $urandom_range(3) == 0
                                : $urandom_range(3) != 0)) po = 1'b1;
            if ($urandom_range(31) == 0) pp = 1'b0;
            if ($urandom_range(31) == 0) po = 1'b0;
            c = ($urandom_range(99) == 0);
            cyc(pp, po, pd, c, ga, ra);
            if (ga) pp = 1'b0;
            if (ra) po = 1'b0;
        end

        for (int i = 0; i < 3; i++) cyc(1, 0, 32'(32'h500 + i), 0, ga, ra);
        push = 1'b1;
        pop  = 1'b0;
        din  = 32'h5ff;
        #2;
        reset_n = 1'b0;
        #1;
        m_reset();
        chk_reset();
        @(negedge clk);
        reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
